// File: rtl/addsub_input_ctrl.sv
// addsub_input_ctrl
//   Operand-entry and result stage for the add/subtract lab design. It feeds the
//   16-bit hex word shown by the 4-digit seven-segment display driver. The block
//   debounces one ENTER button, steps through four phases (enter A, enter B,
//   compute, show) and computes an 8-bit add or subtract with flags.
//
// Ports
//   clk    system clock
//   rst    asynchronous, active-high reset
//   sw     operand switches (asynchronous to clk)
//   sub    0 = A+B, 1 = A-B; sampled only in the compute cycle
//   btn    raw ENTER button, active-high and bouncy (asynchronous)
//   data   display word: digit3=[15:12] ... digit0=[3:0]
//   cout   add: carry out; sub: borrow (A<B unsigned); valid in SHOW
//   ovf    two's-complement overflow of the 8-bit result; valid in SHOW
//   phase  current state code, drives the LEDs
module addsub_input_ctrl #(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  sw,
   input  logic        sub,
   input  logic        btn,
   output logic [15:0] data,
   output logic        cout,
   output logic        ovf,
   output logic [1:0]  phase
);

   localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      CALC    = 2'd2,
      SHOW    = 2'd3
   } state_t;

   typedef struct packed {
      logic       sub;
      logic       cout;
      logic       ovf;
      logic [7:0] res;
   } calc_t;

   // ---------------- input synchronisers ----------------
   logic [7:0] sw_m, sw_s;
   logic       btn_m, btn_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_m  <= '0;
         sw_s  <= '0;
         btn_m <= 1'b0;
         btn_s <= 1'b0;
      end else begin
         sw_m  <= sw;
         sw_s  <= sw_m;
         btn_m <= btn;
         btn_s <= btn_m;
      end
   end

   // ---------------- debounce ----------------
   // The counter only runs while the synchronised button disagrees with the
   // accepted level. Any return to agreement restarts it, so short glitches
   // never reach the accepted level.
   logic [CW-1:0] deb_cnt;
   logic          deb, deb_q;
   logic          press;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb_cnt <= '0;
         deb     <= 1'b0;
         deb_q   <= 1'b0;
      end else begin
         deb_q <= deb;
         if (btn_s == deb) begin
            deb_cnt <= '0;
         end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
            deb     <= ~deb;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + CW'(1);
         end
      end
   end

   // A rising edge of the accepted level is an event. A release is not.
   assign press = deb & ~deb_q;

   // ---------------- arithmetic ----------------
   logic [7:0] op_a, op_b;
   logic [8:0] sum9;
   calc_t      calc_nxt, r;

   always_comb begin
      sum9          = {1'b0, op_a} + (sub ? ({1'b0, ~op_b} + 9'd1) : {1'b0, op_b});
      calc_nxt.sub  = sub;
      calc_nxt.res  = sum9[7:0];
      // For subtraction the 9-bit carry is inverted relative to the borrow,
      // so the borrow is taken straight from the unsigned compare.
      calc_nxt.cout = sub ? (op_a < op_b) : sum9[8];
      calc_nxt.ovf  = sub ? ((op_a[7] != op_b[7]) && (sum9[7] != op_a[7]))
                          : ((op_a[7] == op_b[7]) && (sum9[7] != op_a[7]));
   end

   // ---------------- phase control, operands, display ----------------
   state_t state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ENTER_A;
         op_a  <= '0;
         op_b  <= '0;
         r     <= '0;
         data  <= '0;
      end else begin
         case (state)
            ENTER_A: if (press) begin
               op_a  <= sw_s;
               state <= ENTER_B;
            end
            ENTER_B: if (press) begin
               op_b  <= sw_s;
               state <= CALC;
            end
            CALC: begin
               r     <= calc_nxt;
               state <= SHOW;
            end
            SHOW: if (press) begin
               // The result byte stays; only the flags are cleared.
               r.sub  <= 1'b0;
               r.cout <= 1'b0;
               r.ovf  <= 1'b0;
               state  <= ENTER_A;
            end
            default: state <= ENTER_A;
         endcase

         // The display word follows the current state with one cycle of latency.
         case (state)
            ENTER_A: data <= {4'hA, 4'h0, sw_s};
            ENTER_B: data <= {4'hB, 4'h0, sw_s};
            CALC:    data <= data;
            SHOW:    data <= {3'b000, r.sub, 3'b000, r.cout, r.res};
            default: data <= data;
         endcase
      end
   end

   assign cout  = r.cout;
   assign ovf   = r.ovf;
   assign phase = state;

endmodule

// File: tb/tb_addsub_input_ctrl.sv
module tb_addsub_input_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  sw  = 8'h00;
   logic        sub = 1'b0;
   logic        btn = 1'b0;
   logic [15:0] data;
   logic        cout, ovf;
   logic [1:0]  phase;

   int n_cmp = 0;
   int n_err = 0;

   addsub_input_ctrl #(.DEB_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .sw(sw), .sub(sub), .btn(btn),
      .data(data), .cout(cout), .ovf(ovf), .phase(phase)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Clean press: the state changes 7 cycles after btn rises. The release
   // wait lets the debounced level fall back to 0 before the next press.
   task automatic press();
      btn = 1'b1;
      step(7);
      btn = 1'b0;
      step(9);
   endtask

   // Enter A and B from ENTER_A, then wait until SHOW is displayed.
   task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [15:0] exp_d,
                        input logic exp_c, input logic exp_v);
      sw = a;
      step(3);
      press();
      chk({tag, "_phaseB"}, {14'd0, phase}, 16'd1);
      sw  = b;
      sub = s;
      step(3);
      press();
      chk({tag, "_phase"}, {14'd0, phase}, 16'd3);
      chk({tag, "_data"},  data, exp_d);
      chk({tag, "_cout"},  {15'd0, cout}, {15'd0, exp_c});
      chk({tag, "_ovf"},   {15'd0, ovf},  {15'd0, exp_v});
   endtask

   initial begin
      // ---------- reset state ----------
      step(2);
      chk("rst_data",  data, 16'h0000);
      chk("rst_phase", {14'd0, phase}, 16'd0);
      chk("rst_flags", {14'd0, cout, ovf}, 16'd0);
      rst = 1'b0;
      step(3);
      chk("idle_data", data, 16'hA000);

      // ---------- bounce then steady press ----------
      btn = 1'b1; step(1);
      btn = 1'b0; step(1);
      btn = 1'b1; step(1);
      btn = 1'b0; step(1);
      btn = 1'b1;             // final 0->1 edge
      step(6);
      chk("bounce_early", {14'd0, phase}, 16'd0);
      step(1);
      chk("bounce_adv", {14'd0, phase}, 16'd1);
      step(4);
      btn = 1'b0;
      step(10);
      chk("bounce_once", {14'd0, phase}, 16'd1);
      chk("entB_data", data, 16'hB000);

      // Finish this operation (0 + 0) to get back to ENTER_A.
      press();
      chk("zero_data", data, 16'h0000);
      press();
      chk("back_A", {14'd0, phase}, 16'd0);

      // ---------- arithmetic cases ----------
      do_op("add_ovf",  8'h7F, 8'h01, 1'b0, 16'h0080, 1'b0, 1'b1);
      press();
      do_op("sub_borrow", 8'h05, 8'h07, 1'b1, 16'h11FE, 1'b1, 1'b0);
      press();
      chk("flags_clr", {14'd0, cout, ovf}, 16'd0);
      do_op("add_wrap", 8'hFF, 8'h01, 1'b0, 16'h0100, 1'b1, 1'b0);
      press();
      chk("wrap_ret_phase", {14'd0, phase}, 16'd0);
      chk("wrap_ret_data", data, 16'hA001);

      // ---------- switch change racing the press pulse ----------
      // btn rises at E. The pulse is in the cycle after E+6. The raw switch
      // changes after E+5, so sw_s still holds 8'h12 during the pulse.
      sub = 1'b0;
      sw  = 8'h12;
      step(3);
      btn = 1'b1;
      step(5);
      sw = 8'h34;
      step(2);
      chk("race_phase", {14'd0, phase}, 16'd1);
      btn = 1'b0;
      step(9);
      chk("race_dispB", data, 16'hB034);
      sw = 8'h01;
      step(3);
      press();
      chk("race_res", data, 16'h0013);
      press();

      // ---------- reset in CALC ----------
      sw = 8'h40; step(3); press();
      sw = 8'h02; step(3);
      btn = 1'b1;
      step(7);
      chk("calc_reached", {14'd0, phase}, 16'd2);
      rst = 1'b1;
      #1;
      chk("rstC_data",  data, 16'h0000);
      chk("rstC_phase", {14'd0, phase}, 16'd0);
      btn = 1'b0;
      step(2);
      rst = 1'b0;
      step(10);

      // ---------- reset in SHOW ----------
      do_op("pre_rst", 8'h80, 8'h80, 1'b0, 16'h0100, 1'b1, 1'b1);
      sw  = 8'h55;
      rst = 1'b1;
      #1;
      chk("rstS_data",  data, 16'h0000);
      chk("rstS_phase", {14'd0, phase}, 16'd0);
      chk("rstS_flags", {14'd0, cout, ovf}, 16'd0);
      step(2);
      rst = 1'b0;
      step(1);
      chk("post_rst1", {8'd0, data[15:8]}, 16'h00A0);
      step(2);
      chk("post_rst3", data, 16'hA055);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
